// File: rtl/rsa_input_ctrl.sv
// Push-button operand editor and launch/timeout sequencer for an RSA core.
// Operands are edited nibble by nibble, then one core run is launched and its result shown.
module rsa_input_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             btn_up,
    input  logic                                             btn_down,
    input  logic                                             btn_next,
    input  logic                                             btn_start,
    input  logic                                             core_busy,
    input  logic                                             core_done,
    input  logic [WIDTH-1:0]                                 core_result,
    output logic                                             core_start,
    output logic [WIDTH-1:0]                                 op_n,
    output logic [WIDTH-1:0]                                 op_e,
    output logic [WIDTH-1:0]                                 op_m,
    output logic [WIDTH-1:0]                                 disp_value,
    output logic [1:0]                                       disp_field,
    output logic [((WIDTH/4 > 1) ? $clog2(WIDTH/4) : 1)-1:0] disp_digit,
    output logic                                             err
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned DIG_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_EDIT_N = 3'd0;
    localparam logic [2:0] S_EDIT_E = 3'd1;
    localparam logic [2:0] S_EDIT_M = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_SHOW   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIG_W-1:0] cursor_q, cursor_d;
    logic [WIDTH-1:0] op_n_q, op_n_d, op_e_q, op_e_d, op_m_q, op_m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             core_start_q, core_start_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] edit_val, edit_new;
    logic [3:0]       cur_nib, new_nib;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EDIT_N;
            cursor_q     <= '0;
            op_n_q       <= '0;
            op_e_q       <= '0;
            op_m_q       <= '0;
            result_q     <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            op_n_q       <= op_n_d;
            op_e_q       <= op_e_d;
            op_m_q       <= op_m_d;
            result_q     <= result_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic; cursor 0 addresses the most significant nibble
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        op_n_d       = op_n_q;
        op_e_d       = op_e_q;
        op_m_d       = op_m_q;
        result_d     = result_q;
        core_start_d = 1'b0;
        err_d        = err_q;
        cnt_d        = cnt_q;
        cur_nib      = 4'h0;

        case (state_q)
            S_EDIT_E: edit_val = op_e_q;
            S_EDIT_M: edit_val = op_m_q;
            default:  edit_val = op_n_q;
        endcase

        for (int unsigned i = 0; i < NIB; i++) begin
            if (cursor_q == DIG_W'(NIB - 1 - i)) begin
                cur_nib = edit_val[4*i +: 4];
            end
        end
        new_nib  = btn_up ? (cur_nib + 4'd1) : (cur_nib - 4'd1);
        edit_new = edit_val;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (cursor_q == DIG_W'(NIB - 1 - i)) begin
                edit_new[4*i +: 4] = new_nib;
            end
        end

        case (state_q)
            S_EDIT_N, S_EDIT_E, S_EDIT_M: begin
                if (btn_start) begin
                    state_d = S_LAUNCH;
                end else if (btn_next) begin
                    if (cursor_q == DIG_W'(NIB - 1)) begin
                        cursor_d = '0;
                        state_d  = (state_q == S_EDIT_N) ? S_EDIT_E :
                                   (state_q == S_EDIT_E) ? S_EDIT_M : S_EDIT_N;
                    end else begin
                        cursor_d = cursor_q + DIG_W'(1);
                    end
                end else if (btn_up || btn_down) begin
                    case (state_q)
                        S_EDIT_E: op_e_d = edit_new;
                        S_EDIT_M: op_m_d = edit_new;
                        default:  op_n_d = edit_new;
                    endcase
                end
            end
            S_LAUNCH: begin
                if (!core_busy) begin
                    core_start_d = 1'b1;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done pulse in the final counted cycle still beats the timeout
                if (core_done) begin
                    result_d = core_result;
                    err_d    = 1'b0;
                    state_d  = S_SHOW;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHOW: begin
                if (btn_next || btn_start) begin
                    cursor_d = '0;
                    state_d  = S_EDIT_N;
                end
            end
            default: begin
                cursor_d = '0;
                state_d  = S_EDIT_N;
            end
        endcase
    end

    // Display decode from registered state only
    always_comb begin
        disp_value = result_q;
        disp_field = 2'd3;
        case (state_q)
            S_EDIT_N: begin disp_value = op_n_q; disp_field = 2'd0; end
            S_EDIT_E: begin disp_value = op_e_q; disp_field = 2'd1; end
            S_EDIT_M: begin disp_value = op_m_q; disp_field = 2'd2; end
            default: ;
        endcase
    end

    assign core_start = core_start_q;
    assign op_n       = op_n_q;
    assign op_e       = op_e_q;
    assign op_m       = op_m_q;
    assign disp_digit = cursor_q;
    assign err        = err_q;

endmodule

// File: doc/rsa_input_ctrl.md
RSA_INPUT_CTRL -- requirements
Module: rsa_input_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits; it SHALL be a multiple of 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 100000000, the maximum number of clk cycles to wait for core_done.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; 100 MHz on-board oscillator.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports btn_up, btn_down, btn_next and btn_start, each input, 1 bit: single-cycle pulses from the upstream button debouncers.
REQ-006 The block SHALL have ports core_busy and core_done, each input, 1 bit: RSA core status; core_done is a one-cycle pulse.
REQ-007 The block SHALL have port core_result, input, WIDTH bits: RSA core output, valid in the core_done cycle.
REQ-008 The block SHALL have port core_start, output, 1 bit: one-cycle start pulse to the RSA core.
REQ-009 The block SHALL have ports op_n, op_e and op_m, each output, WIDTH bits: modulus, exponent and message registers.
REQ-010 The block SHALL have port disp_value, output, WIDTH bits: value to display.
REQ-011 The block SHALL have port disp_field, output, 2 bits: 0=n, 1=e, 2=m, 3=result.
REQ-012 The block SHALL have port disp_digit, output, clog2(WIDTH/4) bits: nibble cursor; 0 = most significant nibble.
REQ-013 The block SHALL have port err, output, 1 bit: timeout flag.

Function
REQ-014 The FSM SHALL have states EDIT_N, EDIT_E, EDIT_M, LAUNCH, WAIT and SHOW, all registered.
REQ-015 In the EDIT_* states, btn_up SHALL increment the nibble under the cursor of the selected operand modulo 16, with F->0 wrap and no carry into adjacent nibbles.
REQ-016 In the EDIT_* states, btn_down SHALL decrement that nibble modulo 16, with 0->F wrap and no borrow.
REQ-017 In the EDIT_* states, btn_next SHALL advance the cursor by one nibble toward the LSB.
REQ-018 When btn_next arrives with the cursor on the last nibble, the field SHALL advance EDIT_N->EDIT_E->EDIT_M->EDIT_N and the cursor SHALL return to 0.
REQ-019 btn_start in any EDIT_* state SHALL move the FSM to LAUNCH, and operand registers SHALL be unchanged that cycle.
REQ-020 When several button pulses arrive in the same cycle, priority SHALL be btn_start > btn_next > btn_up > btn_down, and lower-priority pulses SHALL be discarded.
REQ-021 In LAUNCH, the FSM SHALL wait while core_busy=1; in the first cycle with core_busy=0 it SHALL assert core_start for exactly one cycle, clear err and go to WAIT.
REQ-022 In WAIT, all buttons SHALL be ignored and op_n, op_e and op_m SHALL be held constant.
REQ-023 In WAIT, a cycle counter SHALL count from 0.
REQ-024 In WAIT, core_done SHALL load core_result into the result register, and the FSM SHALL go to SHOW with err=0.
REQ-025 If the WAIT counter reaches TIMEOUT-1 without core_done, the FSM SHALL set err=1, leave the result register unchanged and go to SHOW.
REQ-026 If core_done and the timeout coincide, core_done SHALL win.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 In SHOW, btn_next or btn_start SHALL return the FSM to EDIT_N with cursor 0; operands SHALL be retained and err SHALL hold until the next LAUNCH.
REQ-029 btn_up and btn_down SHALL be ignored in SHOW.
REQ-030 disp_value SHALL equal the operand selected by the current EDIT_* state; in LAUNCH, WAIT and SHOW it SHALL equal the result register.
REQ-031 disp_field SHALL be 0/1/2 in EDIT_N/EDIT_E/EDIT_M respectively and 3 otherwise.
REQ-032 All outputs SHALL be driven from registers or a decode of registers only, with no combinational path from inputs.

Reset
REQ-033 rst_n=0 SHALL immediately, independent of clk, force: state=EDIT_N, cursor=0, op_n=op_e=op_m=0, result=0, core_start=0, err=0 and WAIT counter=0.
REQ-034 Assertion of rst_n during WAIT SHALL abandon the operation; a later core_done SHALL be ignored.
REQ-035 On deassertion of rst_n, the first state transition SHALL occur no earlier than the first clk edge after rst_n is sampled high.

Verification
REQ-036 The bench SHALL cover: after reset, 3x btn_up, btn_next, 1x btn_down -> op_n=16'h3F00, disp_digit=1, disp_field=0.
REQ-037 The bench SHALL cover: 4x btn_next from EDIT_N cursor 0 -> EDIT_E, cursor 0; a further 8x btn_next -> EDIT_N again.
REQ-038 The bench SHALL cover: btn_start with core_busy=1 for 5 cycles -> core_start stays 0 until core_busy falls, then exactly one high cycle.
REQ-039 The bench SHALL cover: core_done with core_result=16'h1234 in WAIT -> disp_value=16'h1234, disp_field=3 and err=0 in the next cycle; btn_up during WAIT leaves the operands unchanged.
REQ-040 The bench SHALL cover: TIMEOUT=20 with no core_done -> SHOW with err=1 exactly 20 cycles after the core_start cycle.
REQ-041 The bench SHALL cover: btn_start and btn_up in the same cycle -> LAUNCH with the operand unchanged; rst_n pulsed low mid-WAIT -> all outputs return to reset values without a clk edge.
